mexiko_rst_seq: RTL and testbench

Reset sequencer that sits directly upstream of the top-level reset fan-out. It replaces the raw pass-through of the board reset with a synchronised, staged release: network transceivers first, then the SoC. It supervises the network reset-done handshake with timeout and bounded retry, and produces the board-level `resetdone_o` indication. It also re-sequences on a software reset request from the SoC.

---
 rtl/mexiko_rst_seq.sv | 186 ++++++++++++++++++
 tb/tb_mexiko_rst_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mexiko_rst_seq.sv
// Reset sequencer: synchronised reset release, staged network-then-SoC bring-up,
// network reset-done supervision with timeout/retry, and software re-sequencing.
module mexiko_rst_seq #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned NET_TIMEOUT = 4096,
  parameter int unsigned SOC_DELAY   = 8,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic                             sys_clk_i,
  input  logic                             sys_rst_i,
  input  logic                             sw_rst_req_i,
  input  logic                             net_resetdone_i,
  output logic                             net_rst_o,
  output logic                             soc_rst_o,
  output logic                             resetdone_o,
  output logic                             net_fail_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt_o,
  output logic [2:0]                       state_o
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned MaxA   = (HOLD_CYCLES > NET_TIMEOUT) ? HOLD_CYCLES : NET_TIMEOUT;
  localparam int unsigned MaxCnt = (MaxA > SOC_DELAY) ? MaxA : SOC_DELAY;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0]   HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(NET_TIMEOUT - 1);
  localparam logic [CntW-1:0]   SocLast     = CntW'(SOC_DELAY - 1);
  localparam logic [RetryW-1:0] RetryLast   = RetryW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StNetWait  = 3'd1,
    StNetRetry = 3'd2,
    StSocWait  = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5,
    StFailRun  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_cnt_q, retry_cnt_d;
  logic              net_fail_q, net_fail_d;
  logic              soc_up_q, soc_up_d;
  logic              net_rst_q, net_rst_d;
  logic              soc_rst_q, soc_rst_d;
  logic              resetdone_q, resetdone_d;
  logic              rst_meta_q, rst_sync_q;
  logic              done_meta_q, done_sync_q;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Done is meaningless while the network is held in reset; clearing on the next-state value
  // lets an already-high done be seen two edges after the network reset is released.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
    end else if (net_rst_d) begin
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
    end else begin
      done_meta_q <= net_resetdone_i;
      done_sync_q <= done_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;
    net_fail_d  = net_fail_q;
    soc_up_d    = soc_up_q;

    unique case (state_q)
      StHold, StNetRetry: begin
        if (cnt_q == HoldLast) begin
          state_d = StNetWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNetWait: begin
        if (done_sync_q) begin
          state_d     = soc_up_q ? StRun : StSocWait;
          retry_cnt_d = '0;
          cnt_d       = '0;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d       = '0;
          retry_cnt_d = retry_cnt_q + 1'b1;
          if (retry_cnt_q < RetryLast) begin
            state_d = StNetRetry;
          end else begin
            state_d    = StFail;
            net_fail_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSocWait: begin
        if (cnt_q == SocLast) begin
          soc_up_d = 1'b1;
          cnt_d    = '0;
          state_d  = net_fail_q ? StFailRun : StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!done_sync_q) begin
          state_d     = StNetRetry;
          retry_cnt_d = '0;
          cnt_d       = '0;
        end
      end
      // The failure edge counts as the first cycle of the SoC release delay.
      StFail: begin
        if (soc_up_q) begin
          state_d = StFailRun;
        end else if (cnt_q == SocLast) begin
          soc_up_d = 1'b1;
          cnt_d    = '0;
          state_d  = StFailRun;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StSocWait;
        end
      end
      StFailRun: ;
      default: state_d = StHold;
    endcase

    if (rst_sync_q || sw_rst_req_i) begin
      state_d     = StHold;
      cnt_d       = '0;
      retry_cnt_d = '0;
      net_fail_d  = 1'b0;
      soc_up_d    = 1'b0;
    end

    net_rst_d   = (state_d inside {StHold, StNetRetry, StFail, StFailRun}) || net_fail_d;
    soc_rst_d   = ~soc_up_d;
    resetdone_d = (state_d == StRun);
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      net_fail_q  <= 1'b0;
      soc_up_q    <= 1'b0;
      net_rst_q   <= 1'b1;
      soc_rst_q   <= 1'b1;
      resetdone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      net_fail_q  <= net_fail_d;
      soc_up_q    <= soc_up_d;
      net_rst_q   <= net_rst_d;
      soc_rst_q   <= soc_rst_d;
      resetdone_q <= resetdone_d;
    end
  end

  assign net_rst_o   = net_rst_q;
  assign soc_rst_o   = soc_rst_q;
  assign resetdone_o = resetdone_q;
  assign net_fail_o  = net_fail_q;
  assign retry_cnt_o = retry_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mexiko_rst_seq.sv
// Self-checking bench for mexiko_rst_seq: expected output timelines are computed from the
// sequencing rules with edge arithmetic, relative to a reference edge of each scenario.
module tb_mexiko_rst_seq;

  localparam int Hold = 4;
  localparam int Tmo = 20;
  localparam int SocDly = 3;
  localparam int MaxRetry = 2;

  localparam logic [2:0] SHold = 3'd0, SWait = 3'd1, SRetry = 3'd2, SSoc = 3'd3;
  localparam logic [2:0] SRun = 3'd4, SFail = 3'd5, SFailRun = 3'd6;
  localparam logic [8:0] RstVec = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0};

  logic       clk = 1'b0;
  logic       rst, sw, done;
  logic       net_rst, soc_rst, rd, fail;
  logic [1:0] retry;
  logic [2:0] state;
  logic [8:0] obs;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mexiko_rst_seq #(
    .HOLD_CYCLES(Hold),
    .NET_TIMEOUT(Tmo),
    .SOC_DELAY  (SocDly),
    .MAX_RETRIES(MaxRetry)
  ) dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .sw_rst_req_i   (sw),
    .net_resetdone_i(done),
    .net_rst_o      (net_rst),
    .soc_rst_o      (soc_rst),
    .resetdone_o    (rd),
    .net_fail_o     (fail),
    .retry_cnt_o    (retry),
    .state_o        (state)
  );

  assign obs = {net_rst, soc_rst, rd, fail, retry, state};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert, release, and advance to E1 (synchroniser output falls) with done at a given level.
  task automatic reboot(input logic d);
    rst = 1'b1;
    step();
    done = d;
    rst = 1'b0;
    step();
    step();
  endtask

  // Boot with done already high, k edges after the reference edge.
  function automatic logic [8:0] exp_boot(input int k);
    logic nr, sr;
    logic [2:0] st;
    nr = (k < Hold);
    sr = (k < Hold + 2 + SocDly);
    if (k < Hold) st = SHold;
    else if (k < Hold + 2) st = SWait;
    else if (k < Hold + 2 + SocDly) st = SSoc;
    else st = SRun;
    return {nr, sr, ~sr, 1'b0, 2'b00, st};
  endfunction

  task automatic test_reset();
    int n;
    #1;
    n_checks++;
    if (obs !== RstVec) $display("FAIL reset_async got=%b want=%b", obs, RstVec);
    else n_pass++;
    n = int'($urandom_range(5, 2));
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if (obs !== RstVec) $display("FAIL reset_hold i=%0d got=%b want=%b", i, obs, RstVec);
      else n_pass++;
    end
    done = 1'b1;
    rst = 1'b0;
    step();
    n_checks++;
    if (obs !== RstVec) $display("FAIL reset_e0 got=%b want=%b", obs, RstVec);
    else n_pass++;
    step();
  endtask

  task automatic test_boot(input string name);
    logic [8:0] e;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      e = exp_boot(k);
      n_checks++;
      if (obs !== e) $display("FAIL %s k=%0d got=%b want=%b", name, k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_link_drop();
    int l, t_run, w;
    bit retried;
    logic nr, dn;
    logic [1:0] rc;
    logic [2:0] st;
    logic [8:0] e;
    l = int'($urandom_range(40, 20));
    w = (l > 6) ? l : 6;
    retried = (w + 2 > 26);
    if (retried) t_run = ((l > 30) ? l : 30) + 2;
    else t_run = w + 2;
    for (int k = 0; k <= t_run + 2; k++) begin
      done = (k >= l);
      step();
      nr = (k >= 2 && k < 6) || (retried && k >= 26 && k < 30);
      dn = (k < 2) || (k >= t_run);
      rc = (retried && k >= 26 && k < t_run) ? 2'd1 : 2'd0;
      if (k < 2) st = SRun;
      else if (k < 6) st = SRetry;
      else if (k >= t_run) st = SRun;
      else if (!retried || k < 26) st = SWait;
      else if (k < 30) st = SRetry;
      else st = SWait;
      e = {nr, 1'b0, dn, 1'b0, rc, st};
      n_checks++;
      if (obs !== e) $display("FAIL link_drop l=%0d k=%0d got=%b want=%b", l, k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int j;
    logic [8:0] e;
    j = int'($urandom_range(15, 1));
    reboot(1'b0);
    for (int k = 0; k < Hold + j; k++) step();
    e = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, SWait};
    n_checks++;
    if (obs !== e) $display("FAIL async_pre j=%0d got=%b want=%b", j, obs, e);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== RstVec) $display("FAIL async_assert got=%b want=%b", obs, RstVec);
    else n_pass++;
    @(negedge clk);
    step();
    done = 1'b1;
    rst = 1'b0;
    step();
    step();
    test_boot("async_restart");
  endtask

  task automatic test_single_retry();
    int d, t_sw, t_run;
    logic nr, sr;
    logic [1:0] rc;
    logic [2:0] st;
    logic [8:0] e;
    d = int'($urandom_range(15, 1));
    t_sw = Hold + Tmo + Hold + d + 2;
    t_run = t_sw + SocDly;
    reboot(1'b0);
    for (int k = 1; k <= t_run + 2; k++) begin
      done = (k >= 28 + d);
      step();
      nr = (k < 4) || (k >= 24 && k < 28);
      sr = (k < t_run);
      rc = (k >= 24 && k < t_sw) ? 2'd1 : 2'd0;
      if (k < 4) st = SHold;
      else if (k < 24) st = SWait;
      else if (k < 28) st = SRetry;
      else if (k < t_sw) st = SWait;
      else if (k < t_run) st = SSoc;
      else st = SRun;
      e = {nr, sr, ~sr, 1'b0, rc, st};
      n_checks++;
      if (obs !== e) $display("FAIL single_retry d=%0d k=%0d got=%b want=%b", d, k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_net_fail();
    logic nr, sr, f;
    logic [1:0] rc;
    logic [2:0] st;
    logic [8:0] e;
    reboot(1'b0);
    for (int k = 1; k <= 60; k++) begin
      step();
      nr = (k < 4) || (k >= 24 && k < 28) || (k >= 48);
      sr = (k < 51);
      f = (k >= 48);
      rc = (k < 24) ? 2'd0 : (k < 48) ? 2'd1 : 2'd2;
      if (k < 4) st = SHold;
      else if (k < 24) st = SWait;
      else if (k < 28) st = SRetry;
      else if (k < 48) st = SWait;
      else if (k == 48) st = SFail;
      else if (k < 51) st = SSoc;
      else st = SFailRun;
      e = {nr, sr, 1'b0, f, rc, st};
      n_checks++;
      if (obs !== e) $display("FAIL net_fail k=%0d got=%b want=%b", k, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_sw_rst_fail_run();
    int n;
    logic [8:0] e;
    n = int'($urandom_range(5, 1));
    e = {1'b1, 1'b0, 1'b0, 1'b1, 2'd2, SFailRun};
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if (obs !== e) $display("FAIL fail_run_idle i=%0d got=%b want=%b", i, obs, e);
      else n_pass++;
    end
    sw = 1'b1;
    done = 1'b1;
    step();
    sw = 1'b0;
    test_boot("sw_reboot");
  endtask

  task automatic test_sw_in_hold();
    int m;
    sw = 1'b1;
    step();
    sw = 1'b0;
    m = int'($urandom_range(3, 1));
    for (int i = 0; i < m; i++) begin
      step();
      n_checks++;
      if (obs !== RstVec) $display("FAIL hold_first i=%0d got=%b want=%b", i, obs, RstVec);
      else n_pass++;
    end
    sw = 1'b1;
    step();
    sw = 1'b0;
    test_boot("hold_restart");
  endtask

  initial begin
    rst = 1'b1;
    sw = 1'b0;
    done = 1'b0;
    test_reset();
    test_boot("clean_boot");
    test_link_drop();
    test_async_reset();
    test_single_retry();
    test_net_fail();
    test_sw_rst_fail_run();
    test_sw_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
